load_store_unit: RTL and testbench

// - Memory-stage load/store engine: takes one load/store from the EX/MEM pipeline register, runs a

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine.
// Takes one load/store from EX/MEM and runs one req/gnt/rvalid transaction to data memory.
// Only one transaction is ever outstanding. Load data comes back aligned and sign/zero
// extended for the writeback mux.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid_i/req_we_i    memory op present / store select
//   funct3_i, addr_i        access size/sign and byte address
//   wdata_i                 store data (low bits)
//   flush_i                 squash the current op
//   stall_o                 hold the pipeline while an op is pending
//   resp_valid_o, ld_data_o completion pulse and extended load data (0 for stores)
//   err_o                   misaligned or illegal access pulse, no memory access made
//   mem_*                   data memory req/gnt/rvalid port
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   input  logic                  req_we_i,
   input  logic [2:0]            funct3_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] ld_data_o,
   output logic                  err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  resp_valid_q;
   logic                  err_q;
   logic                  flushed_q;
   logic [DATA_WIDTH-1:0] ld_data_q;

   logic                  accept;
   logic                  bad_f3;
   logic                  misaligned;
   logic                  req_err;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wdata_repl;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_ext;

   // An op still presented in its own resp/err cycle must not be accepted a second time.
   assign accept  = (state_q == IDLE) & req_valid_i & ~resp_valid_q & ~err_q & ~flush_i;
   assign stall_o = req_valid_i & ~resp_valid_q & ~err_q & ~flush_i;

   // Unsigned sizes exist for loads only.
   assign bad_f3 = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111) |
                   (funct3_i[2] & req_we_i);
   assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                       ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
   assign req_err = bad_f3 | misaligned;

   always_comb begin
      be         = 4'b1111;
      wdata_repl = wdata_q;
      unique case (funct3_q[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_q[1:0];
            wdata_repl = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << addr_q[1:0];
            wdata_repl = {2{wdata_q[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_repl = wdata_q;
         end
      endcase
   end

   assign ld_byte = mem_rdata_i[8*addr_q[1:0] +: 8];
   assign ld_half = mem_rdata_i[16*addr_q[1] +: 16];

   always_comb begin
      ld_ext = mem_rdata_i;
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && !req_err) state_d = REQ;
         REQ: begin
            if (mem_gnt_i)    state_d = WAIT;
            else if (flush_i) state_d = IDLE;
         end
         WAIT: if (mem_rvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         flushed_q    <= 1'b0;
         ld_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= funct3_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            err_q    <= req_err;
         end
         // A flush after the grant cannot cancel the access; only the response is dropped.
         if (state_q == REQ && mem_gnt_i) begin
            flushed_q <= flush_i;
         end
         if (state_q == WAIT) begin
            if (mem_rvalid_i) begin
               flushed_q <= 1'b0;
               if (!flushed_q && !flush_i) begin
                  resp_valid_q <= 1'b1;
                  ld_data_q    <= we_q ? '0 : ld_ext;
               end
            end else begin
               flushed_q <= flushed_q | flush_i;
            end
         end
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign err_o        = err_q;
   assign ld_data_o    = ld_data_q;
   assign mem_req_o    = (state_q == REQ);
   assign mem_we_o     = mem_req_o & we_q;
   assign mem_be_o     = mem_req_o ? be : 4'b0000;
   assign mem_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata_o  = wdata_repl;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, flush_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic        stall_o, resp_valid_o, err_o, mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] ld_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;

   int total = 0, bad = 0;

   // Memory responder: grant after gnt_wait stalled cycles, rvalid rv_wait cycles after the
   // cycle following the grant.
   int gnt_wait = 0, rv_wait = 0, req_cnt, pend_cnt;
   logic pending;
   logic [31:0] rdata_val = '0;

   assign mem_gnt_i    = mem_req_o && (req_cnt >= gnt_wait);
   assign mem_rvalid_i = pending && (pend_cnt >= rv_wait);
   assign mem_rdata_i  = rdata_val;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt <= 0; pending <= 1'b0; pend_cnt <= 0;
      end else begin
         req_cnt <= (mem_req_o && !mem_gnt_i) ? req_cnt + 1 : 0;
         if (mem_req_o && mem_gnt_i) begin
            pending <= 1'b1; pend_cnt <= 0;
         end else if (pending) begin
            if (mem_rvalid_i) pending <= 1'b0;
            else pend_cnt <= pend_cnt + 1;
         end
      end
   end

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .stall_o(stall_o), .resp_valid_o(resp_valid_o), .ld_data_o(ld_data_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   // Observations from the last issued op.
   int          r_cyc;
   logic        r_resp, r_err, r_saw_req, r_changed, r_stall_gap, r_stall_end, r_we;
   logic [31:0] r_data, r_addr, r_wd;
   logic [3:0]  r_be;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present one op and follow it until resp/err or a 40-cycle budget; cycle 0 = accept.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      tick();
      req_valid_i = 1'b1; req_we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
      r_cyc = -1; r_resp = 0; r_err = 0; r_saw_req = 0; r_changed = 0; r_stall_gap = 0;
      r_stall_end = 1; r_data = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_req_o) begin
            if (!r_saw_req) begin
               r_saw_req = 1; r_addr = mem_addr_o; r_be = mem_be_o; r_wd = mem_wdata_o;
               r_we = mem_we_o;
            end else if (r_addr !== mem_addr_o || r_be !== mem_be_o || r_wd !== mem_wdata_o ||
                         r_we !== mem_we_o) begin
               r_changed = 1;
            end
         end
         if (resp_valid_o) begin r_resp = 1; r_data = ld_data_o; end
         if (err_o) r_err = 1;
         if (r_resp || r_err) begin r_cyc = i; r_stall_end = stall_o; break; end
         if (!stall_o) r_stall_gap = 1;
         if (i < 39) tick();
      end
      req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({mem_req_o, mem_we_o, mem_be_o, resp_valid_o, err_o, stall_o} !== 9'd0) begin
         bad++; $display("FAIL reset_ctrl got %b want 0",
                         {mem_req_o, mem_we_o, mem_be_o, resp_valid_o, err_o, stall_o});
      end
      total++;
      if (ld_data_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
         bad++; $display("FAIL reset_data got %h/%h/%h want 0", ld_data_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_lb();
      gnt_wait = 0; rv_wait = 0; rdata_val = 32'h80FF_0000;
      issue(1'b0, 3'b000, 32'h1003, 32'd0);
      total++;
      if (r_addr !== 32'h1000 || r_be !== 4'b1000 || r_we !== 1'b0) begin
         bad++; $display("FAIL lb_req got addr %h be %b we %b want 1000/1000/0", r_addr, r_be, r_we);
      end
      total++;
      if (!r_resp || r_cyc != 3 || r_data !== 32'hFFFF_FF80) begin
         bad++; $display("FAIL lb_resp got resp %0d cyc %0d data %h want 1/3/ffffff80",
                         r_resp, r_cyc, r_data);
      end
      total++;
      if (r_stall_gap || r_stall_end !== 1'b0) begin
         bad++; $display("FAIL lb_stall got gap %0d end %0d want 0/0", r_stall_gap, r_stall_end);
      end
      rdata_val = 32'h0000_80FF;
      issue(1'b0, 3'b100, 32'h1001, 32'd0);
      total++;
      if (r_data !== 32'h0000_0080 || r_be !== 4'b0010) begin
         bad++; $display("FAIL lbu got data %h be %b want 00000080/0010", r_data, r_be);
      end
   endtask

   task automatic test_half();
      rdata_val = 32'h8001_1234;
      issue(1'b0, 3'b101, 32'h2002, 32'd0);
      total++;
      if (r_be !== 4'b1100 || r_data !== 32'h0000_8001) begin
         bad++; $display("FAIL lhu got be %b data %h want 1100/00008001", r_be, r_data);
      end
      issue(1'b0, 3'b001, 32'h2002, 32'd0);
      total++;
      if (r_data !== 32'hFFFF_8001) begin
         bad++; $display("FAIL lh got %h want ffff8001", r_data);
      end
      rdata_val = 32'hCAFE_F00D;
      issue(1'b0, 3'b010, 32'h3004, 32'd0);
      total++;
      if (r_data !== 32'hCAFE_F00D || r_be !== 4'b1111 || r_addr !== 32'h3004) begin
         bad++; $display("FAIL lw got data %h be %b addr %h want cafef00d/1111/3004",
                         r_data, r_be, r_addr);
      end
   endtask

   task automatic test_store();
      issue(1'b1, 3'b000, 32'h10, 32'h1234_56AB);
      total++;
      if (r_we !== 1'b1 || r_be !== 4'b0001 || r_wd !== 32'hABAB_ABAB) begin
         bad++; $display("FAIL sb_req got we %b be %b wd %h want 1/0001/abababab", r_we, r_be, r_wd);
      end
      total++;
      if (!r_resp || r_cyc != 3 || r_data !== 32'd0) begin
         bad++; $display("FAIL sb_resp got resp %0d cyc %0d data %h want 1/3/0", r_resp, r_cyc, r_data);
      end
      issue(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
      total++;
      if (r_be !== 4'b1100 || r_wd !== 32'hBEEF_BEEF || r_addr !== 32'h20) begin
         bad++; $display("FAIL sh_req got be %b wd %h addr %h want 1100/beefbeef/20", r_be, r_wd, r_addr);
      end
   endtask

   task automatic test_errors();
      logic [2:0] f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
      logic       wes [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] as [4] = '{32'h6, 32'h8, 32'h5, 32'h4};
      for (int k = 0; k < 4; k++) begin
         issue(wes[k], f3s[k], as[k], 32'h55);
         total++;
         if (!r_err || r_resp || r_cyc != 1 || r_saw_req || r_stall_end !== 1'b0) begin
            bad++; $display("FAIL err_%0d got err %0d resp %0d cyc %0d req %0d stall %0d want 1/0/1/0/0",
                            k, r_err, r_resp, r_cyc, r_saw_req, r_stall_end);
         end
      end
   endtask

   task automatic test_wait_states();
      gnt_wait = 3; rv_wait = 1; rdata_val = 32'h1122_3344;
      issue(1'b0, 3'b001, 32'h402, 32'd0);
      total++;
      if (!r_resp || r_cyc != 7 || r_data !== 32'h0000_1122) begin
         bad++; $display("FAIL slow_resp got resp %0d cyc %0d data %h want 1/7/00001122",
                         r_resp, r_cyc, r_data);
      end
      total++;
      if (r_changed || r_stall_gap || r_addr !== 32'h400 || r_be !== 4'b1100) begin
         bad++; $display("FAIL slow_stable got chg %0d gap %0d addr %h be %b want 0/0/400/1100",
                         r_changed, r_stall_gap, r_addr, r_be);
      end
      tick(); @(negedge clk);
      total++;
      if (resp_valid_o !== 1'b0) begin
         bad++; $display("FAIL slow_single got %b want 0", resp_valid_o);
      end
      gnt_wait = 0; rv_wait = 0;
   endtask

   task automatic test_flush();
      int pulses = 0;
      gnt_wait = 0; rv_wait = 3;
      tick();
      req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h40;
      tick(); tick();  // now in WAIT
      flush_i = 1'b1; req_valid_i = 1'b0;
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
         bad++; $display("FAIL flush_wait got stall %b req %b want 0/0", stall_o, mem_req_o);
      end
      tick(); flush_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); if (resp_valid_o) pulses++;
         tick();
      end
      total++;
      if (pulses != 0) begin
         bad++; $display("FAIL flush_noresp got %0d pulses want 0", pulses);
      end
      rv_wait = 0; rdata_val = 32'h0BAD_F00D;
      issue(1'b0, 3'b010, 32'h44, 32'd0);
      total++;
      if (!r_resp || r_cyc != 3 || r_data !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL flush_idle got resp %0d cyc %0d data %h want 1/3/0badf00d",
                         r_resp, r_cyc, r_data);
      end
      // Flush while the request is still ungranted drops it immediately.
      gnt_wait = 5;
      tick();
      req_valid_i = 1'b1; req_we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h80;
      tick();
      flush_i = 1'b1; req_valid_i = 1'b0;
      tick(); flush_i = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         bad++; $display("FAIL flush_req got req %b resp %b want 0/0", mem_req_o, resp_valid_o);
      end
   endtask

   task automatic test_reset_mid();
      gnt_wait = 8;
      tick();
      req_valid_i = 1'b1; req_we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h8; wdata_i = 32'hDEAD_BEEF;
      tick(); tick();
      @(negedge clk);
      total++;
      if (mem_req_o !== 1'b1) begin
         bad++; $display("FAIL rst_pre got req %b want 1", mem_req_o);
      end
      #2; req_valid_i = 1'b0; rst_n = 1'b0; #1;
      total++;
      if ({mem_req_o, mem_we_o, mem_be_o, resp_valid_o, err_o, stall_o} !== 9'd0 ||
          mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0 || ld_data_o !== 32'd0) begin
         bad++; $display("FAIL rst_mid got ctrl %b addr %h wd %h ld %h want all 0",
                         {mem_req_o, mem_we_o, mem_be_o, resp_valid_o, err_o, stall_o},
                         mem_addr_o, mem_wdata_o, ld_data_o);
      end
      @(negedge clk); rst_n = 1'b1; gnt_wait = 0;
      rdata_val = 32'h7F00_0000;
      issue(1'b0, 3'b000, 32'h13, 32'd0);
      total++;
      if (!r_resp || r_cyc != 3 || r_data !== 32'h0000_007F) begin
         bad++; $display("FAIL rst_after got resp %0d cyc %0d data %h want 1/3/0000007f",
                         r_resp, r_cyc, r_data);
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_half();
      test_store();
      test_errors();
      test_wait_states();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
